// File: rtl/magcomp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package magcomp_pkg;

  // Controller states: waiting for a request, or walking the slices.
  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Result encoding, one-hot {AGB, AEB, ALB}.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so the slice walk itself never needs to know about signedness.
  function automatic logic msb_xform(input logic msb, input logic sgn);
    return msb ^ sgn;
  endfunction

endpackage

// File: rtl/magcomp_slice.sv
// Combinational DIGIT-bit unsigned comparator for one operand slice.
module magcomp_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // Plain unsigned relations on the slice.
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/magcomp_seq.sv
// Sequential magnitude comparator: walks DIGIT-bit slices MSB first and
// stops at the first slice that differs. start/busy/done handshake.
module magcomp_seq
  import magcomp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AGB,
  output logic             AEB,
  output logic             ALB
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  // Slice views of the latched operands; slice 0 is the most significant.
  logic [DIGIT-1:0] a_slc [NSLICE];
  logic [DIGIT-1:0] b_slc [NSLICE];

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slc[gi] = a_q[WIDTH-1-gi*DIGIT -: DIGIT];
      assign b_slc[gi] = b_q[WIDTH-1-gi*DIGIT -: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] a_cur, b_cur;
  logic             slc_gt, slc_eq, slc_lt;

  assign a_cur = a_slc[idx_q];
  assign b_cur = b_slc[idx_q];

  magcomp_slice #(.DIGIT(DIGIT)) u_slice (
    .a  (a_cur),
    .b  (b_cur),
    .gt (slc_gt),
    .eq (slc_eq),
    .lt (slc_lt)
  );

  // Next-state logic: latch on start in IDLE, decide or advance in CMP.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d            = A;
          b_d            = B;
          a_d[WIDTH-1]   = msb_xform(A[WIDTH-1], sgn);
          b_d[WIDTH-1]   = msb_xform(B[WIDTH-1], sgn);
          idx_d          = '0;
          state_d        = CMP;
        end
      end
      CMP: begin
        if (slc_gt) begin
          res_d   = RES_GT;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (slc_lt) begin
          res_d   = RES_LT;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (slc_eq && (idx_q == LAST_IDX)) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any compare and clears flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign AGB  = res_q[2];
  assign AEB  = res_q[1];
  assign ALB  = res_q[0];

endmodule

// File: tb/tb_magcomp_seq.sv
// Scoreboard bench for magcomp_seq (WIDTH=8, DIGIT=2).
module tb_magcomp_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       AGB;
  logic       AEB;
  logic       ALB;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         due;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   n_vec      = 0;
  int   n_miss     = 0;
  int   req_id     = 0;

  magcomp_seq #(.WIDTH(8), .DIGIT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .AGB   (AGB),
    .AEB   (AEB),
    .ALB   (ALB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time-stamp requests and completions.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse pops one expectation and checks flags and edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec  = n_vec + 1;
        n_miss = n_miss + 1;
        $display("FAIL unexpected_done edge=%0d flags=%b", cyc, {AGB, AEB, ALB});
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_vec = n_vec + 1;
        if ({AGB, AEB, ALB} !== e.res || cyc != e.due) begin
          n_miss = n_miss + 1;
          $display("FAIL req%0d_result got flags=%b edge=%0d want flags=%b edge=%0d",
                   e.id, {AGB, AEB, ALB}, cyc, e.res, e.due);
        end else begin
          $display("req%0d ok flags=%b edge=%0d", e.id, e.res, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_miss = n_miss + 1;
      $display("FAIL %s got %b want %b", name, got, want);
    end else begin
      $display("%s ok %b", name, got);
    end
  endtask

  // Drive one start pulse; when push is set, register the expected result
  // deciding at slice k (done edge = E0 + k + 1).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic push, input logic [2:0] res, input int k);
    exp_t e;
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      req_id = req_id + 1;
      e.res = res;
      e.due = cyc + k + 1;
      e.id  = req_id;
      sb.push_back(e);
      $display("req%0d issued A=%h B=%h sgn=%b", req_id, a, b, s);
    end
  endtask

  // Bounded wait for all outstanding expectations to be consumed.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec  = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; sgn = 1'b0; A = 8'h01; B = 8'h00;
    // Reset held 2 cycles with start asserted.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, AGB, AEB, ALB}, 5'b00000);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", {busy, done, AGB, AEB, ALB}, 5'b00000);

    // Equal operands, worst-case latency; busy must be up right after E0.
    issue(8'h5A, 8'h5A, 1'b0, 1'b1, EQ, 3);
    check("busy_after_start", {busy, done, 3'b000}, 5'b10000);
    repeat (2) @(posedge clk);
    #1;
    check("busy_mid_compare", {busy, done, 3'b000}, 5'b10000);
    drain();

    // Early exit, unsigned then signed on the same operands.
    issue(8'hC0, 8'h3F, 1'b0, 1'b1, GT, 0);
    drain();
    issue(8'hC0, 8'h3F, 1'b1, 1'b1, LT, 0);
    drain();
    // Signed extremes: 127 > -128, and -128 == -128.
    issue(8'h7F, 8'h80, 1'b1, 1'b1, GT, 0);
    drain();
    issue(8'h80, 8'h80, 1'b1, 1'b1, EQ, 3);
    drain();

    // LSB-slice decision, then back-to-back start on the done cycle.
    issue(8'h12, 8'h13, 1'b0, 1'b1, LT, 3);
    repeat (4) @(posedge clk);
    #1;
    check("done_cycle_not_busy", {busy, done, AGB, AEB, ALB}, 5'b01001);
    issue(8'hFF, 8'h00, 1'b0, 1'b1, GT, 0);
    drain();

    // Start while busy is ignored.
    issue(8'h01, 8'h01, 1'b0, 1'b1, EQ, 3);
    issue(8'hFF, 8'h00, 1'b0, 1'b0, 3'b000, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_idle", {busy, done, AGB, AEB, ALB}, 5'b00010);

    // Reset mid-operation aborts without a done pulse.
    issue(8'h00, 8'h01, 1'b0, 1'b0, 3'b000, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_reset", {busy, done, AGB, AEB, ALB}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", {busy, done, AGB, AEB, ALB}, 5'b00000);
    issue(8'h00, 8'h01, 1'b0, 1'b1, LT, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
